argmax_top2: RTL and testbench

ARGMAX_TOP2 -- requirements
Module: argmax_top2

---
 rtl/argmax_top2_pkg.sv | 23 ++
 rtl/argmax_top2_cmp.sv | 40 ++++
 rtl/argmax_top2.sv | 161 ++++++++++++++++
 tb/tb_argmax_top2.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_top2_pkg.sv
// Shared classifier definitions: logit count, logit width, class-index width, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package argmax_top2_pkg;

  // Number of logits produced by the fully-connected classifier stage
  localparam int N_CLASSES = 10;

  // Signed width of each logit
  localparam int DATA_W = 32;

  // Width of the winning class index reported to software
  localparam int IDX_W = 4;

  // Classifier controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/argmax_top2_cmp.sv
// Top-2 tracker step: folds one logit into the running (best, second, best index) triple.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
module top2_cmp #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                     first_i,
  input  logic signed [DATA_W-1:0] val_i,
  input  logic        [IDX_W-1:0]  idx_i,
  input  logic signed [DATA_W-1:0] best_i,
  input  logic signed [DATA_W-1:0] second_i,
  input  logic        [IDX_W-1:0]  best_idx_i,
  output logic signed [DATA_W-1:0] best_o,
  output logic signed [DATA_W-1:0] second_o,
  output logic        [IDX_W-1:0]  best_idx_o
);

  // Most negative representable logit; the runner-up starts here so any real value beats it
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Strict '>' keeps the earliest index on ties; an equal later value lands in second
  always_comb begin
    best_o     = best_i;
    second_o   = second_i;
    best_idx_o = best_idx_i;
    if (first_i) begin
      best_o     = val_i;
      second_o   = MOST_NEG;
      best_idx_o = idx_i;
    end else if (val_i > best_i) begin
      second_o   = best_i;
      best_o     = val_i;
      best_idx_o = idx_i;
    end else if (val_i > second_i) begin
      second_o   = val_i;
    end
  end

endmodule

// File: rtl/argmax_top2.sv
// Argmax with runner-up: snapshots the logits, scans one per cycle, reports index/max/second/margin.
// Latency: start sampled at edge N -> done visible after edge N+N_CLASSES+2.
// Backpressure: none; start is only honoured in IDLE, requests while busy/done are dropped.
module argmax_top2 #(
  parameter int N_CLASSES = argmax_top2_pkg::N_CLASSES,
  parameter int DATA_W    = argmax_top2_pkg::DATA_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic signed [N_CLASSES-1:0][DATA_W-1:0] logits,
  output logic                                   busy,
  output logic                                   done,
  output logic [argmax_top2_pkg::IDX_W-1:0]      class_idx,
  output logic signed [DATA_W-1:0]               max_val,
  output logic signed [DATA_W-1:0]               second_val,
  output logic        [DATA_W-1:0]               margin
);

  import argmax_top2_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  // Controller state
  state_t state_q;
  state_t state_d;

  // Frozen copy of the logits so upstream may move on once the snapshot is taken
  logic [N_CLASSES-1:0][DATA_W-1:0] snap_q;

  // Index of the snapshot entry evaluated this cycle
  logic [IDX_W-1:0] cnt_q;

  // Running scan results
  logic signed [DATA_W-1:0] best_q;
  logic signed [DATA_W-1:0] second_q;
  logic        [IDX_W-1:0]  bidx_q;

  // Next values offered by the compare stage
  logic signed [DATA_W-1:0] cmp_best;
  logic signed [DATA_W-1:0] cmp_second;
  logic        [IDX_W-1:0]  cmp_idx;

  // Published results, only touched on the DONE transition
  logic                     done_q;
  logic        [IDX_W-1:0]  class_idx_q;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] second_val_q;
  logic        [DATA_W-1:0] margin_q;

  // One extra bit so the subtraction itself can never overflow
  logic signed [DATA_W:0]   diff;

  assign diff = $signed({best_q[DATA_W-1], best_q}) - $signed({second_q[DATA_W-1], second_q});

  top2_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .first_i    (cnt_q == '0),
    .val_i      ($signed(snap_q[cnt_q])),
    .idx_i      (cnt_q),
    .best_i     (best_q),
    .second_i   (second_q),
    .best_idx_i (bidx_q),
    .best_o     (cmp_best),
    .second_o   (cmp_second),
    .best_idx_o (cmp_idx)
  );

  // State register; reset aborts any scan in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a single pass IDLE -> SNAP -> SCAN (N_CLASSES cycles) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SNAP;
      ST_SNAP: state_d = ST_SCAN;
      ST_SCAN: if (cnt_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: busy covers the snapshot and scan phases only
  always_comb begin
    busy = 1'b0;
    case (state_q)
      ST_SNAP: busy = 1'b1;
      ST_SCAN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Snapshot capture, once per accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else if (state_q == ST_SNAP) begin
      snap_q <= logits;
    end
  end

  // Scan index: cleared while snapshotting, advanced once per scan cycle, parked on the last entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_SNAP) begin
      cnt_q <= '0;
    end else if (state_q == ST_SCAN && cnt_q != LAST_IDX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Running top-2 accumulator, fed by the compare stage during the scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_q   <= '0;
      second_q <= '0;
      bidx_q   <= '0;
    end else if (state_q == ST_SCAN) begin
      best_q   <= cmp_best;
      second_q <= cmp_second;
      bidx_q   <= cmp_idx;
    end
  end

  // Publish results and pulse done on leaving DONE; outputs hold between completions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q       <= 1'b0;
      class_idx_q  <= '0;
      max_q        <= '0;
      second_val_q <= '0;
      margin_q     <= '0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        class_idx_q  <= bidx_q;
        max_q        <= best_q;
        second_val_q <= second_q;
        // best >= second always holds, so the sign bit stays clear; clamp defensively if it ever does not
        margin_q     <= diff[DATA_W] ? '0 : diff[DATA_W-1:0];
      end
    end
  end

  assign done       = done_q;
  assign class_idx  = class_idx_q;
  assign max_val    = max_q;
  assign second_val = second_val_q;
  assign margin     = margin_q;

endmodule

// File: tb/tb_argmax_top2.sv
// Self-checking bench for argmax_top2: directed corner vectors plus randomized logits.
// Expected results come from a two-pass argmax model over the input vector.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_argmax_top2;

  import argmax_top2_pkg::*;

  localparam int RES_W = IDX_W + 3 * DATA_W;
  localparam int LAT   = N_CLASSES + 2;

  typedef logic [N_CLASSES-1:0][DATA_W-1:0] vec_t;
  typedef logic [RES_W-1:0] res_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  vec_t logits;
  logic busy;
  logic done;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] second_val;
  logic [DATA_W-1:0] margin;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  argmax_top2 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .logits     (logits),
    .busy       (busy),
    .done       (done),
    .class_idx  (class_idx),
    .max_val    (max_val),
    .second_val (second_val),
    .margin     (margin)
  );

  always #5 clk = ~clk;

  function automatic res_t cur_res();
    return {class_idx, max_val, second_val, margin};
  endfunction

  // Reference: first occurrence of the maximum, then the maximum of every other entry
  function automatic res_t model(input vec_t v);
    longint mx;
    longint sc;
    longint x;
    int     bi;
    mx = longint'($signed(v[0]));
    bi = 0;
    for (int i = 1; i < N_CLASSES; i++) begin
      x = longint'($signed(v[i]));
      if (x > mx) begin
        mx = x;
        bi = i;
      end
    end
    sc = -(longint'(1) <<< (DATA_W - 1));
    for (int j = 0; j < N_CLASSES; j++) begin
      if (j != bi) begin
        x = longint'($signed(v[j]));
        if (x > sc) sc = x;
      end
    end
    return {IDX_W'(bi), DATA_W'(mx), DATA_W'(sc), DATA_W'(mx - sc)};
  endfunction

  function automatic vec_t rand_vec(input int mode);
    vec_t v;
    for (int i = 0; i < N_CLASSES; i++) begin
      case (mode)
        0:       v[i] = DATA_W'($urandom());
        1:       v[i] = DATA_W'(int'($urandom_range(0, 6)) - 3);
        default: v[i] = DATA_W'(int'($urandom_range(0, 2000)) - 1000);
      endcase
    end
    return v;
  endfunction

  // Issue one request and wait (bounded) for done; optionally disturb inputs during the scan
  task automatic run_class(input vec_t v, input bit scramble, output int lat,
                           output bit saw_busy, output bit held, output bit one_pulse);
    res_t prev;
    prev      = cur_res();
    held      = 1'b1;
    lat       = -1;
    logits    = v;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    saw_busy  = busy;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (cur_res() !== prev) held = 1'b0;
      if (scramble) begin
        for (int i = 0; i < N_CLASSES; i++) logits[i] = DATA_W'($urandom());
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    @(negedge clk);
    one_pulse = !done;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    logits = '0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, done, cur_res()} !== '0)
      $display("FAIL reset_state: got %h want 0", {busy, done, cur_res()});
    else pass_cnt++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, done, cur_res()} !== '0)
      $display("FAIL idle_after_release: got %h want 0", {busy, done, cur_res()});
    else pass_cnt++;
  endtask

  task automatic test_directed();
    int   a [N_CLASSES];
    vec_t v;
    int   lat;
    bit   sb, hd, op;
    res_t exp;

    a = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
    for (int i = 0; i < N_CLASSES; i++) v[i] = DATA_W'(a[i]);
    exp = {4'd2, 32'd12, 32'd11, 32'd1};
    run_class(v, 1'b0, lat, sb, hd, op);
    chk_cnt++;
    if (lat !== LAT) $display("FAIL latency_basic: got %0d want %0d", lat, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (sb !== 1'b1) $display("FAIL busy_after_start: got %b want 1", sb);
    else pass_cnt++;
    chk_cnt++;
    if (op !== 1'b1) $display("FAIL done_one_cycle: second cycle done=%b want 0", !op);
    else pass_cnt++;
    chk_cnt++;
    if (cur_res() !== exp) $display("FAIL result_basic: got %h want %h", cur_res(), exp);
    else pass_cnt++;

    for (int i = 0; i < N_CLASSES; i++) v[i] = 32'hFFFF_FF9C;
    exp = {4'd0, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd0};
    run_class(v, 1'b0, lat, sb, hd, op);
    chk_cnt++;
    if (lat !== LAT) $display("FAIL latency_all_equal: got %0d want %0d", lat, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (cur_res() !== exp) $display("FAIL result_all_equal: got %h want %h", cur_res(), exp);
    else pass_cnt++;

    for (int i = 0; i < N_CLASSES; i++) v[i] = 32'h8000_0000;
    v[9] = 32'h7FFF_FFFF;
    exp = {4'd9, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    run_class(v, 1'b0, lat, sb, hd, op);
    chk_cnt++;
    if (cur_res() !== exp) $display("FAIL result_extremes: got %h want %h", cur_res(), exp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    vec_t v;
    res_t exp;
    int   lat;
    bit   sb, hd, op;
    for (int it = 0; it < 12; it++) begin
      v   = rand_vec(it % 3);
      exp = model(v);
      run_class(v, 1'b0, lat, sb, hd, op);
      chk_cnt++;
      if (lat !== LAT) $display("FAIL latency_rand%0d: got %0d want %0d", it, lat, LAT);
      else pass_cnt++;
      chk_cnt++;
      if (cur_res() !== exp) $display("FAIL result_rand%0d: got %h want %h", it, cur_res(), exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_snapshot();
    vec_t v;
    res_t exp;
    int   lat;
    int   extra;
    bit   sb, hd, op;
    v   = rand_vec(2);
    exp = model(v);
    run_class(v, 1'b1, lat, sb, hd, op);
    chk_cnt++;
    if (cur_res() !== exp) $display("FAIL snapshot_result: got %h want %h", cur_res(), exp);
    else pass_cnt++;
    chk_cnt++;
    if (op !== 1'b1) $display("FAIL snapshot_one_pulse: second cycle done=%b want 0", !op);
    else pass_cnt++;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk_cnt++;
    if (extra !== 0) $display("FAIL snapshot_no_queue: got %0d extra done want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    vec_t v;
    res_t exp;
    int   lat;
    int   extra;
    bit   sb, hd, op;
    v      = rand_vec(0);
    logits = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL abort_mid_scan_busy: got %b want 1", busy);
    else pass_cnt++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk_cnt++;
    if (extra !== 0) $display("FAIL abort_no_done: got %0d done pulses want 0", extra);
    else pass_cnt++;
    chk_cnt++;
    if ({busy, cur_res()} !== '0) $display("FAIL abort_outputs_zero: got %h want 0", {busy, cur_res()});
    else pass_cnt++;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp   = model(v);
    run_class(v, 1'b0, lat, sb, hd, op);
    chk_cnt++;
    if (lat !== LAT) $display("FAIL first_start_after_reset: latency %0d want %0d", lat, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (cur_res() !== exp) $display("FAIL result_after_abort: got %h want %h", cur_res(), exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    vec_t v1, v2;
    res_t exp1, exp2;
    int   lat;
    bit   sb, hd, op;
    v1    = rand_vec(2);
    v1[4] = DATA_W'(5000);
    v2    = rand_vec(2);
    v2[7] = DATA_W'(6000);
    exp1  = model(v1);
    exp2  = model(v2);
    run_class(v1, 1'b0, lat, sb, hd, op);
    chk_cnt++;
    if (class_idx !== 4'd4) $display("FAIL b2b_first_idx: got %0d want 4", class_idx);
    else pass_cnt++;
    chk_cnt++;
    if (cur_res() !== exp1) $display("FAIL b2b_first_result: got %h want %h", cur_res(), exp1);
    else pass_cnt++;
    run_class(v2, 1'b0, lat, sb, hd, op);
    chk_cnt++;
    if (hd !== 1'b1) $display("FAIL b2b_hold: outputs changed before done (held=%b want 1)", hd);
    else pass_cnt++;
    chk_cnt++;
    if (class_idx !== 4'd7) $display("FAIL b2b_second_idx: got %0d want 7", class_idx);
    else pass_cnt++;
    chk_cnt++;
    if (cur_res() !== exp2) $display("FAIL b2b_second_result: got %h want %h", cur_res(), exp2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_snapshot();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
